// File: rtl/mac_seq_pkg.sv
// Shared types for the sequential MAC: FSM states, command opcodes and the
// iteration-counter width helper.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_MAC     = 2'b00,
        OP_LOAD    = 2'b01,
        OP_CLEAR   = 2'b10,
        OP_SETMODE = 2'b11
    } op_t;

    // Bit-counter width for a W-bit multiplier; at least one bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/spst_add_p.sv
// Split-half adder whose upper half is held at zero, with its inputs gated,
// whenever both upper operands are zero and no carry crosses the split.
module spst_add_p #(
    parameter int N = 20
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int H = N / 2;
    localparam int U = N - H;

    logic [H:0]   lo;
    logic         upper_idle;
    logic [U-1:0] a_hi_g;
    logic [U-1:0] b_hi_g;
    logic [U:0]   hi;
    logic [U-1:0] hi_res;

    assign lo = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]};

    assign upper_idle = (a[N-1:H] == '0) && (b[N-1:H] == '0) && !lo[H];

    // Gated inputs keep the upper adder from toggling while it is bypassed.
    assign a_hi_g = upper_idle ? '0 : a[N-1:H];
    assign b_hi_g = upper_idle ? '0 : b[N-1:H];
    assign hi     = {1'b0, a_hi_g} + {1'b0, b_hi_g} + {{U{1'b0}}, lo[H]};
    assign hi_res = upper_idle ? '0 : hi[U-1:0];

    assign sum  = {hi_res, lo[H-1:0]};
    assign cout = upper_idle ? 1'b0 : hi[U];

endmodule

// File: rtl/mac_seq_spst.sv
// Sequential shift-add multiply-accumulate: W-cycle multiply, one-cycle fold
// into a wide accumulator through the SPST adder, saturate or wrap on carry.
module mac_seq_spst
    import mac_seq_pkg::*;
#(
    parameter int W           = 8,
    parameter int ACC_W       = 20,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_op,
    input  logic             in_sat,
    output logic [ACC_W-1:0] acc,
    output logic             done,
    output logic             ovf,
    output logic             sat_mode
);

    localparam int CW = cnt_w(W);

    // Handshake: a command transfers on a clk edge where in_valid && in_ready;
    // in_ready is high only in IDLE and the source must hold in_valid and its
    // operands stable until that edge.  Operands are not sampled afterwards.

    // state is the single FSM register and is the intended probe point.
    state_t          state;
    state_t          state_nxt;
    op_t             op_reg;
    logic [2*W-1:0]  a_reg;
    logic [W-1:0]    b_reg;
    logic [2*W-1:0]  prod;
    logic [CW-1:0]   count;
    logic            accept;
    logic            mul_last;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic            add_cout;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign mul_last = (count == CW'(W - 1));
    assign prod_ext = ACC_W'(prod);

    spst_add_p #(.N(ACC_W)) u_add (
        .a    (acc),
        .b    (prod_ext),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && (op_t'(in_op) == OP_MAC || op_t'(in_op) == OP_LOAD)) begin
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_nxt = ST_ACC;
                end
            end
            ST_ACC:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            ovf      <= 1'b0;
            sat_mode <= SAT_DEFAULT;
            done     <= 1'b0;
            op_reg   <= OP_MAC;
            a_reg    <= '0;
            b_reg    <= '0;
            prod     <= '0;
            count    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (op_t'(in_op))
                            OP_MAC, OP_LOAD: begin
                                op_reg <= op_t'(in_op);
                                a_reg  <= (2*W)'(in_a);
                                b_reg  <= in_b;
                                prod   <= '0;
                                count  <= '0;
                            end
                            OP_CLEAR: begin
                                acc  <= '0;
                                ovf  <= 1'b0;
                                done <= 1'b1;
                            end
                            OP_SETMODE: begin
                                sat_mode <= in_sat;
                                done     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (b_reg[0]) begin
                        prod <= prod + (a_reg << count);
                    end
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                end
                ST_ACC: begin
                    if (op_reg == OP_LOAD) begin
                        acc <= prod_ext;
                    end else if (add_cout) begin
                        ovf <= 1'b1;
                        acc <= sat_mode ? '1 : add_sum;
                    end else begin
                        acc <= add_sum;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
